// File: rtl/counting_sched.sv
`default_nettype none
// ============================================================================
//  Module      : counting_sched
//  Description : Time-shares one 1-2-3 symbol-sequence detector step among
//                NCH requester channels. Each channel keeps a private
//                detector state. A round-robin arbiter grants one channel per
//                cycle, and only that channel's state is advanced. The block
//                reports completion per channel and keeps a saturating
//                completion counter per channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module counting_sched #(
   parameter int NCH = 4,
   parameter int CW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    req_valid,
   input  logic [2*NCH-1:0]  req_num,
   output logic [NCH-1:0]    req_ready,
   input  logic [NCH-1:0]    clr,
   output logic [NCH-1:0]    done,
   output logic              hit,
   output logic [2:0]        hit_ch,
   output logic [NCH*CW-1:0] cnt
);

   // Pointer width: enough bits to name any channel.
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   // Detector states.
   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;

   // After reset the pointer sits on the last channel, so the search starts
   // at channel 0.
   localparam logic [PW-1:0] PTR_RST = PW'(NCH - 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [1:0]     r_state     [NCH];
   logic [1:0]     w_state_nxt [NCH];
   logic [1:0]     w_sym       [NCH];
   logic [CW-1:0]  r_cnt       [NCH];
   logic [NCH-1:0] w_elig;
   logic [NCH-1:0] w_grant;
   logic           w_gvalid;
   logic [PW-1:0]  w_gidx;
   logic [PW-1:0]  r_ptr;
   logic           w_hit_nxt;
   logic           r_hit;
   logic [2:0]     r_hit_ch;

   // One detector step for an accepted symbol.
   function automatic logic [1:0] step(input logic [1:0] s, input logic [1:0] n);
      logic [1:0] r;
      r = s;
      case (s)
         S0: r = (n == 2'd1) ? S1 : S0;
         S1: begin
            if (n == 2'd2)      r = S2;
            else if (n == 2'd3) r = S0;
            else                r = S1;
         end
         S2: begin
            if (n == 2'd1)      r = S1;
            else if (n == 2'd2) r = S0;
            else                r = S3;
         end
         default: r = S3;
      endcase
      return r;
   endfunction

   // Per-channel symbol unpacking, eligibility and counter output packing.
   // Eligibility is gated by rst_n so that req_ready stays low in reset.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign w_sym[i]           = req_num[2*i +: 2];
      assign w_elig[i]          = rst_n & req_valid[i] & (r_state[i] != S3) & ~clr[i];
      assign cnt[CW*i +: CW]    = r_cnt[i];
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      int cand;
      w_grant  = '0;
      w_gvalid = 1'b0;
      w_gidx   = '0;
      cand     = 0;
      for (int k = 1; k <= NCH; k++) begin
         cand = (int'(r_ptr) + k) % NCH;
         if (!w_gvalid && w_elig[PW'(cand)]) begin
            w_gvalid = 1'b1;
            w_gidx   = PW'(cand);
         end
      end
      if (w_gvalid) begin
         w_grant[w_gidx] = 1'b1;
      end
   end

   assign req_ready = w_grant;

   // Detector state register for all channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= S0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   // Next state: clear wins, otherwise only the granted channel steps.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_state_nxt[i] = r_state[i];
         if (clr[i]) begin
            w_state_nxt[i] = S0;
         end else if (w_grant[i]) begin
            w_state_nxt[i] = step(r_state[i], w_sym[i]);
         end
      end
   end

   // Outputs decoded from state: completion flags and S2->S3 detection.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         done[i] = (r_state[i] == S3);
      end
      w_hit_nxt = w_gvalid && (r_state[w_gidx] == S2) && (w_state_nxt[w_gidx] == S3);
   end

   // Arbiter pointer and registered hit pulse / hit channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr    <= PTR_RST;
         r_hit    <= 1'b0;
         r_hit_ch <= 3'd0;
      end else begin
         if (w_gvalid) begin
            r_ptr <= w_gidx;
         end
         r_hit <= w_hit_nxt;
         if (w_hit_nxt) begin
            r_hit_ch <= 3'(w_gidx);
         end
      end
   end

   assign hit    = r_hit;
   assign hit_ch = r_hit_ch;

   // Saturating per-channel completion counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_hit_nxt && w_grant[i] && (r_cnt[i] != CNT_MAX)) begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_counting_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counting_sched
//  Description : Self-checking bench for counting_sched (NCH=4, CW=2) with a
//                table-driven behavioural model, directed scenarios and a
//                randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counting_sched;

   localparam int NCH  = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NCH-1:0]    req_valid = '0;
   logic [2*NCH-1:0]  req_num = '0;
   logic [NCH-1:0]    req_ready;
   logic [NCH-1:0]    clr = '0;
   logic [NCH-1:0]    done;
   logic              hit;
   logic [2:0]        hit_ch;
   logic [NCH*CW-1:0] cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: transition table indexed [state][symbol].
   int NXT [4][4] = '{'{0, 1, 0, 0},
                      '{1, 1, 2, 0},
                      '{3, 1, 0, 3},
                      '{3, 3, 3, 3}};
   int m_state [NCH];
   int m_cnt   [NCH];
   int m_ptr;
   int m_hit;
   int m_hitch;

   int g, c, ns;
   logic [NCH-1:0]    exp_ready;
   logic [NCH-1:0]    exp_done;
   logic [NCH*CW-1:0] exp_cnt;

   logic [3:0] exp_rr4 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] exp_rr3 [6] = '{4'b0001, 4'b0010, 4'b1000,
                               4'b0001, 4'b0010, 4'b1000};
   int exp_sat [5] = '{1, 2, 3, 3, 3};

   counting_sched #(.NCH(NCH), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_num   (req_num),
      .req_ready (req_ready),
      .clr       (clr),
      .done      (done),
      .hit       (hit),
      .hit_ch    (hit_ch),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: outputs vs model on every falling edge, then advance
   // the model by what the next rising edge must do.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", 64'(req_ready), 64'd0);
         chk("rst_done",  64'(done),      64'd0);
         chk("rst_hit",   64'(hit),       64'd0);
         chk("rst_hitch", 64'(hit_ch),    64'd0);
         chk("rst_cnt",   64'(cnt),       64'd0);
         for (int i = 0; i < NCH; i++) begin
            m_state[i] = 0;
            m_cnt[i]   = 0;
         end
         m_ptr   = NCH - 1;
         m_hit   = 0;
         m_hitch = 0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            exp_done[i]           = (m_state[i] == 3);
            exp_cnt[i*CW +: CW]   = CW'(m_cnt[i]);
         end
         chk("m_done",  64'(done),   64'(exp_done));
         chk("m_hit",   64'(hit),    64'(m_hit));
         chk("m_hitch", 64'(hit_ch), 64'(m_hitch));
         chk("m_cnt",   64'(cnt),    64'(exp_cnt));
         g = -1;
         for (int k = 1; k <= NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (g < 0 && req_valid[c] && m_state[c] != 3 && !clr[c]) g = c;
         end
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         chk("m_ready", 64'(req_ready), 64'(exp_ready));
         m_hit = 0;
         if (g >= 0) begin
            ns = NXT[m_state[g]][int'(req_num[2*g +: 2])];
            if (ns == 3) begin
               m_hit   = 1;
               m_hitch = g;
               if (m_cnt[g] < CMAX) m_cnt[g]++;
            end
            m_state[g] = ns;
            m_ptr      = g;
         end
         for (int i = 0; i < NCH; i++) begin
            if (clr[i]) m_state[i] = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_num   = '0;
      clr       = '0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   // Present one symbol on one channel for one cycle; it must be granted.
   task automatic send(input int ch, input int sym);
      req_valid     = '0;
      req_valid[ch] = 1'b1;
      req_num       = 8'(sym << (2*ch));
      #1;
      chk("send_ready", 64'(req_ready), 64'(1 << ch));
      cyc();
      req_valid = '0;
      req_num   = '0;
   endtask

   task automatic clear(input int ch);
      clr     = '0;
      clr[ch] = 1'b1;
      cyc();
      clr = '0;
   endtask

   initial begin
      #1;
      do_reset();

      // Single channel 1,2,3 on ch0.
      send(0, 1);
      send(0, 2);
      send(0, 3);
      chk("t1_done0", 64'(done[0]),  64'd1);
      chk("t1_hit",   64'(hit),      64'd1);
      chk("t1_hitch", 64'(hit_ch),   64'd0);
      chk("t1_cnt0",  64'(cnt[1:0]), 64'd1);
      req_valid = 4'b0001;
      req_num   = 8'h01;
      #1;
      chk("t1_backpressure", 64'(req_ready), 64'd0);
      req_valid = '0;
      req_num   = '0;
      cyc();

      // Abort paths on ch1.
      send(1, 1); send(1, 3);
      chk("t2_13_model", 64'(m_state[1]), 64'd0);
      chk("t2_13_done",  64'(done[1]),    64'd0);
      send(1, 1); send(1, 2); send(1, 2);
      chk("t2_122_model", 64'(m_state[1]), 64'd0);
      send(1, 1); send(1, 2); send(1, 1); send(1, 2); send(1, 0);
      chk("t2_12120_model", 64'(m_state[1]), 64'd3);
      chk("t2_12120_hit",   64'(hit),        64'd1);
      chk("t2_12120_hitch", 64'(hit_ch),     64'd1);
      chk("t2_12120_done",  64'(done[1]),    64'd1);
      clear(1);
      send(1, 1); send(1, 1); send(1, 1);
      chk("t2_111_model", 64'(m_state[1]), 64'd1);
      chk("t2_111_done",  64'(done[1]),    64'd0);

      // Round-robin order.
      do_reset();
      req_valid = 4'hF;
      req_num   = 8'h55;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t3_rr4", 64'(req_ready), 64'(exp_rr4[i]));
         cyc();
      end
      req_valid = 4'b1011;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("t3_rr3", 64'(req_ready), 64'(exp_rr3[i]));
         cyc();
      end
      req_valid = '0;
      req_num   = '0;

      // clr collides with a completing symbol on ch0.
      do_reset();
      send(0, 1);
      send(0, 2);
      req_valid = 4'b0011;
      req_num   = 8'h03;
      clr       = 4'b0001;
      #1;
      chk("t4_ready", 64'(req_ready), 64'b0010);
      cyc();
      clr       = '0;
      req_valid = '0;
      req_num   = '0;
      chk("t4_done0",  64'(done[0]),    64'd0);
      chk("t4_hit",    64'(hit),        64'd0);
      chk("t4_cnt0",   64'(cnt[1:0]),   64'd0);
      chk("t4_model0", 64'(m_state[0]), 64'd0);

      // Saturation of ch3 counter.
      for (int k = 0; k < 5; k++) begin
         send(3, 1);
         send(3, 2);
         send(3, 3);
         chk("t5_hit",   64'(hit),        64'd1);
         chk("t5_hitch", 64'(hit_ch),     64'd3);
         chk("t5_cnt3",  64'(cnt[7:6]),   64'(exp_sat[k]));
         clear(3);
      end

      // Asynchronous reset with a completing symbol in flight on ch2.
      do_reset();
      send(2, 1);
      send(2, 2);
      req_valid = 4'b0100;
      req_num   = 8'h30;
      #1;
      chk("t6_ready_pre", 64'(req_ready), 64'b0100);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_ready_rst", 64'(req_ready), 64'd0);
      chk("t6_done_rst",  64'(done),      64'd0);
      chk("t6_hit_rst",   64'(hit),       64'd0);
      req_valid = 4'b1100;
      req_num   = 8'h00;
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      chk("t6_first_grant", 64'(req_ready), 64'b0100);
      cyc();
      chk("t6_hit_after", 64'(hit),  64'd0);
      chk("t6_done_after", 64'(done), 64'd0);
      req_valid = '0;

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            cyc();
            cyc();
            rst_n = 1'b1;
         end
         req_valid = 4'($urandom) | 4'($urandom);
         req_num   = 8'($urandom);
         clr       = '0;
         for (int b = 0; b < NCH; b++) begin
            if ($urandom_range(7, 0) == 0) clr[b] = 1'b1;
         end
         cyc();
      end
      req_valid = '0;
      clr       = '0;
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/counting_sched.md
Name: counting_sched

Overview:
- Time-shares one 1-2-3 symbol-sequence detector step among NCH requester channels.
- Each channel delivers a stream of 2-bit symbols over a valid/ready handshake; the block keeps a private detector state per channel.
- Round-robin picks one channel per cycle and advances only that channel's state.
- Reports sequence completion per channel and a saturating completion count per channel; sits between symbol sources and the host status logic.

Parameters:
NCH, 4, number of requester channels (2..8)
CW, 8, width of each per-channel completion counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
req_valid  input  NCH  channel i has a symbol on req_num[2i+1:2i]
req_num  input  2*NCH  packed 2-bit symbols, channel i at [2i+1:2i]
req_ready  output  NCH  one-hot grant (or all-zero); symbol accepted when req_valid[i]&req_ready[i]
clr  input  NCH  per-channel clear of detector state back to S0 (counter untouched)
done  output  NCH  done[i]=1 while channel i state is S3 (combinational from state reg)
hit  output  1  one-cycle registered pulse: some channel entered S3
hit_ch  output  3  index of channel that caused hit; holds last value otherwise
cnt  output  NCH*CW  packed per-channel S3-entry counters, channel i at [CW*(i+1)-1:CW*i]

Behaviour:
- Reset (rst_n=0, async): all channel states S0, rr pointer = NCH-1 (channel 0 has first priority), hit=0, hit_ch=0, all cnt=0; req_ready=0 while in reset.
- Per-channel detector step, applied only to an accepted symbol n:
  - S0: n==1 -> S1; else stay S0.
  - S1: n==2 -> S2; n==3 -> S0; else (0,1) stay S1.
  - S2: n==1 -> S1; n==2 -> S0; else (0,3) -> S3.
  - S3: absorbing; left only via clr[i] or reset.
- Eligibility: channel i is eligible when req_valid[i]=1, state!=S3 and clr[i]=0.
- Arbitration (combinational, same cycle):
  - Search from ptr+1 upward, wrapping modulo NCH; the first eligible channel gets req_ready.
  - At most one bit of req_ready set; none eligible -> req_ready=0.
  - req_ready may depend on req_valid (no req_ready-before-valid requirement).
- On each rising edge with a grant to g:
  - state[g] <= step(state[g], symbol g).
  - ptr <= g.
  - No grant -> ptr unchanged.
- Latency: state update is visible on done[] the cycle after acceptance; hit/hit_ch are registered and asserted that same next cycle.
- hit: set for exactly one cycle when the granted transition is S2->S3.
  - hit_ch <= g in that cycle.
  - cnt[g] increments by 1, saturating at 2^CW-1 (no wrap).
  - Otherwise hit <= 0.
- clr[i]: state[i] <= S0 at next edge, regardless of current state.
  - clr[i] has priority over a grant: channel i is not eligible that cycle, so no symbol is consumed.
  - Multiple clr bits may be set simultaneously.
- Starvation freedom: a continuously eligible channel is granted within NCH cycles.
- Channels in S3 hold req_ready low (backpressure) until cleared; their req_valid is ignored.
- Reset asserted mid-operation: immediate return to reset values, in-flight accepted symbol discarded; first grant after release is the lowest eligible index.
- Symbol value 0 is legal and follows the table above (S2 on 0 -> S3).

Test Plan:
- Single channel: reset, ch0 valid every cycle with symbols 1,2,3 -> req_ready[0]=1 each cycle; done[0]=1 and hit=1 with hit_ch=0 in the cycle after symbol 3 is accepted; cnt ch0=1; afterwards req_ready[0]=0.
- Abort paths on ch1, one symbol per grant:
  - 1,3 -> back in S0.
  - 1,2,2 -> S0.
  - 1,2,1,2,0 -> S3, hit_ch=1.
  - 1,1,1 -> remains S1.
- Round-robin: all 4 channels valid continuously from reset -> grant order 0,1,2,3,0,1...; drop ch2 valid -> order 0,1,3,0,1,3; each channel's states advance independently.
- clr collision: ch0 in S2 presents symbol 3 while clr[0]=1 in the same cycle -> req_ready[0]=0, next cycle state S0, no hit, cnt unchanged; grant goes to next eligible channel.
- Saturation: with CW=2, drive ch3 through complete-then-clear 5 times -> cnt ch3 reads 1,2,3,3,3; hit pulses all 5 times.
- Async reset: assert rst_n=0 mid-cycle while ch2 is in S2 with a granted symbol 3 -> outputs reset immediately, no hit; after release with ch2 and ch3 valid, first grant is ch2.
